if_stage: RTL and testbench

Pipelined instruction-fetch stage placed directly upstream of the decode stage. It owns the PC register and issues word reads to a synchronous instruction memory with a fixed 1-cycle read latency. Returned words are buffered in a small FIFO and handed to decode over a valid/ready handshake. A redirect from the branch-resolution logic flushes the stage and restarts fetch at the target PC.

---
 rtl/if_pkg.sv | 13 +
 rtl/if_fifo.sv | 62 ++++++
 rtl/if_stage.sv | 109 ++++++++++
 tb/tb_if_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int          XLEN        = 32;
    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO of fetch entries; flush wins over push and pop.
module if_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 wdata,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, credit-based imem issue, redirect/kill, decode handshake.
// Optional macro IF_BYPASS_EN lets a response reach decode in its arrival cycle when the FIFO is empty.
module if_stage
    import if_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int                  FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_en,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_plus4
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int CW  = FCW + 1;

    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic                  kill;

    logic                  resp_ok;
    logic                  pop;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [FCW-1:0]        fifo_count;
    logic [CW-1:0]         credit_used;
    fetch_entry_t          resp_entry;
    fetch_entry_t          fifo_head;
    fetch_entry_t          head;

    assign resp_ok          = inflight & !kill & !redirect;
    assign resp_entry.pc    = inflight_pc;
    assign resp_entry.instr = imem_rdata;

`ifdef IF_BYPASS_EN
    logic bypass;
    assign bypass      = fifo_empty & resp_ok;
    assign head        = bypass ? resp_entry : fifo_head;
    assign instr_valid = (!fifo_empty | resp_ok) & !redirect;
    assign pop         = instr_valid & instr_ready;
    assign fifo_pop    = pop & !bypass;
    assign fifo_push   = resp_ok & !(bypass & pop) & (!fifo_full | fifo_pop);
`else
    assign head        = fifo_head;
    assign instr_valid = !fifo_empty & !redirect;
    assign pop         = instr_valid & instr_ready;
    assign fifo_pop    = pop;
    assign fifo_push   = resp_ok & (!fifo_full | fifo_pop);
`endif

    // Entries buffered plus the one in flight, less what leaves this cycle, must fit.
    assign credit_used = CW'(fifo_count) + CW'(inflight) - CW'(pop);
    assign imem_en     = rst & !redirect & (credit_used < CW'(FIFO_DEPTH));
    assign imem_addr   = fetch_pc;

    assign instr    = head.instr;
    assign pc       = head.pc;
    assign pc_plus4 = head.pc + DATA_WIDTH'(INSTR_BYTES);

    if_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (resp_entry),
        .pop   (fifo_pop),
        .flush (redirect),
        .rdata (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // A redirect discards the response still in flight by arming kill for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            kill        <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~DATA_WIDTH'(INSTR_BYTES - 1);
            inflight <= 1'b0;
            kill     <= inflight;
        end else begin
            kill     <= 1'b0;
            inflight <= imem_en;
            if (imem_en) begin
                fetch_pc    <= fetch_pc + DATA_WIDTH'(INSTR_BYTES);
                inflight_pc <= fetch_pc;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomised and directed bench for if_stage against an in-order program-stream model.
module tb_if_stage;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_BYPASS_EN
    localparam int FIRST_LAT = 1;
    localparam int REDIR_LAT = 2;
`else
    localparam int FIRST_LAT = 2;
    localparam int REDIR_LAT = 3;
`endif
    localparam int IDLE_MAX = FIRST_LAT;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int n_checks = 0;
    int n_fail   = 0;

    // Program-stream model: next pc decode must see, next address to be fetched, words owed.
    logic [31:0] exp_pc;
    logic [31:0] next_issue;
    int          outstanding;
    int          since_event;
    int          first_valid_at;
    int          idle_run;
    logic        prev_hold;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;

    if_stage #(
        .DATA_WIDTH (32),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= word_of(imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc         = RESET_PC;
        next_issue     = RESET_PC;
        outstanding    = 0;
        since_event    = 0;
        first_valid_at = -1;
        idle_run       = 0;
        prev_hold      = 1'b0;
    endtask

    task automatic check_cycle();
        logic pop_now;
        if (!rst) return;
        pop_now = instr_valid & instr_ready;
        if (redirect) begin
            check("redirect_valid", {31'b0, instr_valid}, 32'd0);
            check("redirect_en", {31'b0, imem_en}, 32'd0);
        end
        if (imem_en) begin
            check("issue_addr", imem_addr, next_issue);
            check("credit", {31'b0, (outstanding - int'(pop_now)) < DEPTH}, 32'd1);
        end
        if (prev_hold && instr_valid) begin
            check("hold_pc", pc, prev_pc);
            check("hold_instr", instr, prev_instr);
        end
        if (pop_now) begin
            check("deliver_pc", pc, exp_pc);
            check("deliver_instr", instr, word_of(exp_pc));
            check("deliver_pc_plus4", pc_plus4, exp_pc + 32'd4);
        end
        if (instr_valid) begin
            idle_run = 0;
            if (first_valid_at < 0) first_valid_at = since_event;
        end else if (!redirect) begin
            idle_run++;
            check("idle_bound", {31'b0, idle_run <= IDLE_MAX}, 32'd1);
        end
        prev_hold  = instr_valid & !instr_ready;
        prev_pc    = pc;
        prev_instr = instr;
        if (redirect) begin
            exp_pc         = redirect_pc & ~32'd3;
            next_issue     = redirect_pc & ~32'd3;
            outstanding    = 0;
            since_event    = 0;
            first_valid_at = -1;
            idle_run       = 0;
        end else begin
            if (pop_now) begin
                exp_pc = exp_pc + 32'd4;
                outstanding--;
            end
            if (imem_en) begin
                next_issue = next_issue + 32'd4;
                outstanding++;
            end
        end
        since_event++;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        step();
        redirect    = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b1;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", {31'b0, instr_valid}, 32'd0);
        check("reset_en", {31'b0, imem_en}, 32'd0);
        check("reset_instr", instr, 32'd0);
        check("reset_pc", pc, 32'd0);
        check("reset_pc_plus4", pc_plus4, 32'd4);

        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        check("first_issue_addr", imem_addr, RESET_PC);
        repeat (6) step();
        check("first_valid_latency", 32'(first_valid_at), 32'(FIRST_LAT));
        repeat (14) step();

        instr_ready = 1'b0;
        repeat (5) step();
        check("stall_no_issue", {31'b0, imem_en}, 32'd0);
        check("stall_outstanding", 32'(outstanding), 32'(DEPTH));
        instr_ready = 1'b1;
        repeat (8) step();

        do_redirect(32'h0000_0100);
        repeat (5) step();
        check("redirect_penalty", 32'(first_valid_at), 32'(REDIR_LAT));

        instr_ready = 1'b0;
        repeat (4) step();
        do_redirect(32'h0000_0180);
        instr_ready = 1'b1;
        repeat (6) step();

        do_redirect(32'h0000_0203);
        check("misaligned_target", imem_addr, 32'h0000_0200);
        repeat (6) step();

        do_redirect(32'hFFFF_FFF8);
        repeat (8) step();

        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        step();
        redirect_pc = 32'h0000_0400;
        step();
        redirect    = 1'b0;
        check("back_to_back_target", imem_addr, 32'h0000_0400);
        repeat (6) step();
        check("back_to_back_penalty", 32'(first_valid_at), 32'(REDIR_LAT));

        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom % 4) != 0;
            redirect    = ($urandom % 20) == 0;
            redirect_pc = $urandom;
            step();
        end
        redirect    = 1'b0;
        instr_ready = 1'b1;
        repeat (6) step();

        rst = 1'b0;
        #1;
        check("midreset_valid", {31'b0, instr_valid}, 32'd0);
        check("midreset_en", {31'b0, imem_en}, 32'd0);
        check("midreset_pc_plus4", pc_plus4, 32'd4);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        check("restart_addr", imem_addr, RESET_PC);
        repeat (8) step();
        check("restart_latency", 32'(first_valid_at), 32'(FIRST_LAT));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
